// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with per-set round-robin replacement.
// Define ICACHE_FLUSH_EN to add the flush_i (fence.i) input that invalidates every line.
module icache_assoc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] core_inst_addr_i,
  input  logic              core_valid_req_i,
`ifdef ICACHE_FLUSH_EN
  input  logic              flush_i,
`endif
  output logic              Icache_ready_o,
  output logic [DATA_W-1:0] Icache_inst_o,
  output logic              hit,
  output logic              pipe_stall,
  output logic [ADDR_W-1:0] Icache_addr_o,
  output logic              Icache_valid_req_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_data_i
);

  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WORDS  = LINE_W / DATA_W;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} CacheState;

  CacheState r_state, w_nextState;

  logic [ADDR_W-1:0]            r_addr;
  logic [PTR_W-1:0]             r_fillWay;
  logic                         r_flushPending;
  logic [SETS-1:0][WAYS-1:0]    r_valid;
  logic [SETS-1:0][PTR_W-1:0]   r_rrPtr;
  logic [TAG_W-1:0]             r_tag  [WAYS][SETS];
  logic [LINE_W-1:0]            r_data [WAYS][SETS];

  logic              w_flush;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WSEL_W-1:0] w_wsel;
  logic              w_hitAny;
  logic              w_hit;
  logic [PTR_W-1:0]  w_hitWay;
  logic [PTR_W-1:0]  w_victim;
  logic              w_allValid;
  logic [PTR_W-1:0]  w_readWay;
  logic [LINE_W-1:0] w_readLine;
  logic [DATA_W-1:0] w_word;
  logic              w_accept;
  logic              w_fill;
  logic              w_unused;

`ifdef ICACHE_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  assign w_idx      = r_addr[OFF_W +: IDX_W];
  assign w_tag      = r_addr[ADDR_W-1 -: TAG_W];
  assign w_wsel     = (WORDS > 1) ? r_addr[BYTE_W +: WSEL_W] : '0;
  assign w_unused   = ^r_addr;
  assign w_hit      = w_hitAny && !w_flush;
  assign w_accept   = core_valid_req_i && ((r_state == IDLE) || (r_state == LOOKUP && w_hit));
  assign w_fill     = (r_state == MISS) && mem_ready_i;
  assign w_readWay  = (r_state == REFILL) ? r_fillWay : w_hitWay;
  assign w_readLine = r_data[w_readWay][w_idx];
  assign w_word     = w_readLine[DATA_W*w_wsel +: DATA_W];

  always_comb begin
    w_hitAny = 1'b0;
    w_hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hitAny = 1'b1;
        w_hitWay = PTR_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; the round-robin pointer is only a fallback.
  always_comb begin
    w_victim   = r_rrPtr[w_idx];
    w_allValid = &r_valid[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_victim = PTR_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (core_valid_req_i) w_nextState = LOOKUP;
      LOOKUP:  if (!w_hit) w_nextState = MISS;
               else if (!core_valid_req_i) w_nextState = IDLE;
      MISS:    if (mem_ready_i) w_nextState = REFILL;
      REFILL:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    Icache_ready_o     = 1'b0;
    Icache_inst_o      = '0;
    hit                = 1'b0;
    pipe_stall         = 1'b0;
    Icache_addr_o      = '0;
    Icache_valid_req_o = 1'b0;
    case (r_state)
      LOOKUP: begin
        if (w_hit) begin
          Icache_ready_o = 1'b1;
          hit            = 1'b1;
          Icache_inst_o  = w_word;
        end else begin
          pipe_stall = 1'b1;
        end
      end
      MISS: begin
        pipe_stall         = 1'b1;
        Icache_valid_req_o = 1'b1;
        Icache_addr_o      = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
      REFILL: begin
        Icache_ready_o = 1'b1;
        Icache_inst_o  = w_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_fillWay <= '0;
    end else begin
      if (w_accept) r_addr <= core_inst_addr_i;
      if (w_fill)   r_fillWay <= w_victim;
    end
  end

  // A flush seen while a refill is outstanding keeps that line from ever becoming valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= '0;
      r_rrPtr        <= '0;
      r_flushPending <= 1'b0;
    end else if (w_flush) begin
      r_valid        <= '0;
      r_rrPtr        <= '0;
      r_flushPending <= (r_state == MISS) && !mem_ready_i;
    end else if (w_fill) begin
      r_flushPending <= 1'b0;
      if (!r_flushPending) begin
        r_valid[w_idx][w_victim] <= 1'b1;
        if (w_allValid)
          r_rrPtr[w_idx] <= (r_rrPtr[w_idx] == PTR_W'(WAYS - 1)) ? '0 : r_rrPtr[w_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_victim][w_idx] <= mem_data_i;
      r_tag[w_victim][w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: scoreboard of returned instructions plus a vector table.
// Exercises the ICACHE_FLUSH_EN flush sequences when that macro is defined.
module tb_icache_assoc;

  localparam logic [127:0] SPEC_LINE = 128'h1111_0000_1111_0000_1011_0000_1111_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        hit;
  } ExpItem;

  typedef struct {
    logic [31:0] addr;
    int          delay;
    logic        expHit;
  } VecRec;

  logic         clk;
  logic         rst_n;
  logic [31:0]  core_inst_addr_i;
  logic         core_valid_req_i;
  logic         Icache_ready_o;
  logic [31:0]  Icache_inst_o;
  logic         hit;
  logic         pipe_stall;
  logic [31:0]  Icache_addr_o;
  logic         Icache_valid_req_o;
  logic         mem_ready_i;
  logic [127:0] mem_data_i;
`ifdef ICACHE_FLUSH_EN
  logic         flush_i;
`endif

  int     vecCount  = 0;
  int     missCount = 0;
  int     memDelay  = 1;
  int     waitCnt   = 0;
  bit     memEnable = 1'b1;
  bit     specLine  = 1'b1;
  ExpItem expQ[$];
  VecRec  vecs[$];

  icache_assoc dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .core_inst_addr_i   (core_inst_addr_i),
    .core_valid_req_i   (core_valid_req_i),
`ifdef ICACHE_FLUSH_EN
    .flush_i            (flush_i),
`endif
    .Icache_ready_o     (Icache_ready_o),
    .Icache_inst_o      (Icache_inst_o),
    .hit                (hit),
    .pipe_stall         (pipe_stall),
    .Icache_addr_o      (Icache_addr_o),
    .Icache_valid_req_o (Icache_valid_req_o),
    .mem_ready_i        (mem_ready_i),
    .mem_data_i         (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image used after the fixed test-plan line: every word encodes its own address.
  function automatic logic [31:0] expWord(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
  endfunction

  function automatic logic [127:0] genLine(input logic [31:0] a);
    logic [127:0] line;
    for (int k = 0; k < 4; k++) line[k*32 +: 32] = expWord({a[31:4], 4'h0} + 32'(k * 4));
    return line;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  // Memory responder: raises mem_ready_i for one cycle after memDelay cycles of a held request.
  always begin
    @(posedge clk);
    #1;
    if (memEnable && Icache_valid_req_o && !mem_ready_i) begin
      waitCnt++;
      if (waitCnt >= memDelay) begin
        mem_ready_i = 1'b1;
        mem_data_i  = specLine ? SPEC_LINE : genLine(Icache_addr_o);
      end
    end else begin
      mem_ready_i = 1'b0;
      waitCnt     = 0;
    end
  end

  // Scoreboard consumer: every ready pulse must match the oldest outstanding expectation.
  always begin
    ExpItem e;
    @(posedge clk);
    #1;
    if (rst_n && Icache_ready_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected ready, scoreboard depth", 64'(expQ.size()), 64'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput($sformatf("inst @0x%0h", e.addr), 64'(Icache_inst_o), 64'(e.inst));
        checkOutput($sformatf("hit @0x%0h", e.addr), 64'(hit), 64'(e.hit));
      end
    end
  end

  // One isolated fetch: checks latency, stall shape, refill address and whether memory was asked.
  task automatic applyStimulus(input logic [31:0] addr, input int delay, input logic expHit,
                               input logic [31:0] expInst, input string name);
    int lat;
    bit done, stallOk, addrOk, reqSeen;
    memDelay         = delay;
    core_inst_addr_i = addr;
    core_valid_req_i = 1'b1;
    expQ.push_back('{addr: addr, inst: expInst, hit: expHit});
    tick();
    core_valid_req_i = 1'b0;
    lat = 0; done = 0; stallOk = 1; addrOk = 1; reqSeen = 0;
    for (int c = 1; c <= 64 && !done; c++) begin
      if (Icache_ready_o) begin
        lat  = c;
        done = 1;
        if (pipe_stall) stallOk = 0;
      end else if (!pipe_stall) begin
        stallOk = 0;
      end
      if (Icache_valid_req_o) begin
        reqSeen = 1;
        if (Icache_addr_o !== {addr[31:4], 4'h0}) addrOk = 0;
      end
      if (!done) tick();
    end
    checkOutput({name, " latency"}, 64'(lat), expHit ? 64'd1 : 64'(delay + 2));
    checkOutput({name, " stall shape"}, 64'(stallOk), 64'd1);
    checkOutput({name, " refill addr"}, 64'(addrOk), 64'd1);
    checkOutput({name, " refill requested"}, 64'(reqSeen), 64'(!expHit));
    tick();
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic runStreaming();
    logic [31:0] words [4];
    words[0] = 32'h1111_0000;
    words[1] = 32'h1011_0000;
    words[2] = 32'h1111_0000;
    words[3] = 32'h1111_0000;
    core_valid_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_inst_addr_i = 32'(i * 4);
      expQ.push_back('{addr: 32'(i * 4), inst: words[i], hit: 1'b1});
      tick();
      checkOutput($sformatf("stream ready %0d", i), 64'(Icache_ready_o), 64'd1);
      checkOutput($sformatf("stream stall %0d", i), 64'(pipe_stall), 64'd0);
    end
    core_valid_req_i = 1'b0;
    tick();
    checkOutput("stream ends", 64'(Icache_ready_o), 64'd0);
  endtask

  task automatic runResetMidRefill();
    int n;
    memEnable        = 1'b0;
    core_inst_addr_i = 32'h40;
    core_valid_req_i = 1'b1;
    tick();
    core_valid_req_i = 1'b0;
    n = 0;
    while (!Icache_valid_req_o && n < 10) begin
      tick();
      n++;
    end
    checkOutput("refill pending before reset", 64'(Icache_valid_req_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset valid_req", 64'(Icache_valid_req_o), 64'd0);
    checkOutput("async reset stall", 64'(pipe_stall), 64'd0);
    checkOutput("async reset addr", 64'(Icache_addr_o), 64'd0);
    checkOutput("async reset ready", 64'(Icache_ready_o), 64'd0);
    checkOutput("async reset inst", 64'(Icache_inst_o), 64'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    memEnable = 1'b1;
    tick();
    applyStimulus(32'h4, 2, 1'b0, 32'h1011_0000, "post-reset 0x4");
  endtask

`ifdef ICACHE_FLUSH_EN
  task automatic runFlush();
    int n;
    pulseReset();
    applyStimulus(32'h0, 1, 1'b0, expWord(32'h0), "flush fill 0x0");
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    applyStimulus(32'h4, 2, 1'b0, expWord(32'h4), "after flush 0x4");
    memDelay         = 4;
    core_inst_addr_i = 32'h40;
    core_valid_req_i = 1'b1;
    expQ.push_back('{addr: 32'h40, inst: expWord(32'h40), hit: 1'b0});
    tick();
    core_valid_req_i = 1'b0;
    tick();
    checkOutput("flush-in-miss refill pending", 64'(Icache_valid_req_o), 64'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n = 0;
    while (!Icache_ready_o && n < 20) begin
      tick();
      n++;
    end
    checkOutput("flush-in-miss response", 64'(Icache_ready_o), 64'd1);
    tick();
    applyStimulus(32'h40, 1, 1'b0, expWord(32'h40), "repeat after flush-in-miss");
  endtask
`endif

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    core_inst_addr_i = '0;
    core_valid_req_i = 1'b0;
    mem_ready_i      = 1'b0;
    mem_data_i       = '0;
`ifdef ICACHE_FLUSH_EN
    flush_i          = 1'b0;
`endif

    vecs.push_back('{32'h000, 2, 1'b0});
    vecs.push_back('{32'h100, 1, 1'b0});
    vecs.push_back('{32'h204, 3, 1'b0});
    vecs.push_back('{32'h108, 1, 1'b1});
    vecs.push_back('{32'h00C, 2, 1'b0});
    vecs.push_back('{32'h200, 1, 1'b1});
    vecs.push_back('{32'h104, 1, 1'b0});
    vecs.push_back('{32'h008, 1, 1'b1});
    vecs.push_back('{32'h208, 2, 1'b0});
    vecs.push_back('{32'h10C, 1, 1'b1});
    vecs.push_back('{32'h310, 1, 1'b0});
    vecs.push_back('{32'h314, 1, 1'b1});
    vecs.push_back('{32'h004, 3, 1'b0});
    vecs.push_back('{32'h208, 1, 1'b1});
    vecs.push_back('{32'h100, 2, 1'b0});
    vecs.push_back('{32'h000, 1, 1'b1});

    tick();
    tick();
    checkOutput("reset ready", 64'(Icache_ready_o), 64'd0);
    checkOutput("reset hit", 64'(hit), 64'd0);
    checkOutput("reset stall", 64'(pipe_stall), 64'd0);
    checkOutput("reset valid_req", 64'(Icache_valid_req_o), 64'd0);
    checkOutput("reset addr", 64'(Icache_addr_o), 64'd0);
    checkOutput("reset inst", 64'(Icache_inst_o), 64'd0);
    rst_n = 1'b1;
    tick();

    specLine = 1'b1;
    applyStimulus(32'h1, 4, 1'b0, 32'h1111_0000, "cold miss 0x1");
    applyStimulus(32'h4, 1, 1'b1, 32'h1011_0000, "same-line hit 0x4");
    runStreaming();
    runResetMidRefill();

    pulseReset();
    specLine = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].addr, vecs[i].delay, vecs[i].expHit, expWord(vecs[i].addr),
                    $sformatf("vec%0d 0x%0h", i, vecs[i].addr));
    end

`ifdef ICACHE_FLUSH_EN
    runFlush();
`endif

    tick();
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
